// File: rtl/sine_gen_pkg.sv
// Shared types and default widths for the sine-wave address generator.
// Imported by sine_phase_acc and sine_addr_gen.
package sine_gen_pkg;

    localparam int ADDRESS_WIDTH_DEF = 8;
    localparam int DATA_WIDTH_DEF    = 8;
    localparam int ACC_WIDTH_DEF     = 16;
    localparam int LEN_WIDTH_DEF     = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sine_phase_acc.sv
// Phase accumulator: register, adder, carry-out and ROM address slice.
// Ports: clk, rst_n, clear, advance, incr in; addr, carry out.
module sine_phase_acc
    import sine_gen_pkg::*;
#(
    parameter int ACC_WIDTH     = ACC_WIDTH_DEF,
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     advance,
    input  logic [ACC_WIDTH-1:0]     incr,
    output logic [ADDRESS_WIDTH-1:0] addr,
    output logic                     carry
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum;

    // One extra bit captures the carry that marks an accumulator wrap.
    assign sum   = {1'b0, acc} + {1'b0, incr};
    assign carry = sum[ACC_WIDTH];
    assign addr  = acc[ACC_WIDTH-1 -: ADDRESS_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (advance) begin
            acc <= sum[ACC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/sine_addr_gen.sv
// Address/phase generator for the sine ROM: FSM, burst counter, phase regs.
// Ports: start/stop/en/incr/burst_len/phase_in/phase_load in; addr, phase,
// addr_valid, wrap, rom_valid, busy, done out.
module sine_addr_gen
    import sine_gen_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH     = ACC_WIDTH_DEF,
    parameter int LEN_WIDTH     = LEN_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     en,
    input  logic [ACC_WIDTH-1:0]     incr,
    input  logic [LEN_WIDTH-1:0]     burst_len,
    input  logic [DATA_WIDTH-1:0]    phase_in,
    input  logic                     phase_load,
    output logic [ADDRESS_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0]    phase,
    output logic                     addr_valid,
    output logic                     wrap,
    output logic                     rom_valid,
    output logic                     busy,
    output logic                     done
);

    state_t                state;
    state_t                state_n;
    logic [ACC_WIDTH-1:0]  incr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] pend;
    logic                  carry;
    logic                  accept;
    logic                  issue;
    logic                  last;

    assign accept     = (state == IDLE) && start;
    assign busy       = (state == RUN);
    assign addr_valid = busy && en;
    assign wrap       = addr_valid && carry;
    // stop wins over an issue in the same cycle
    assign issue      = addr_valid && !stop;
    assign last       = (len_q != '0) && (cnt == len_q - LEN_WIDTH'(1));

    sine_phase_acc #(
        .ACC_WIDTH     (ACC_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .advance (issue),
        .incr    (incr_q),
        .addr    (addr),
        .carry   (carry)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = RUN;
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (issue && last) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            incr_q    <= '0;
            len_q     <= '0;
            cnt       <= '0;
            rom_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            rom_valid <= addr_valid;
            done      <= issue && last;
            if (accept) begin
                incr_q <= incr;
                len_q  <= burst_len;
                cnt    <= '0;
            end else if (issue && (cnt != '1)) begin
                // saturates so continuous mode never terminates
                cnt <= cnt + LEN_WIDTH'(1);
            end
        end
    end

    // Phase changes land in IDLE or on a wrap issue, never mid-cycle of
    // the waveform; a load in the applying cycle bypasses the pending reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= '0;
            phase <= '0;
        end else begin
            if (phase_load) pend <= phase_in;
            if ((state == IDLE) || (issue && carry)) begin
                phase <= phase_load ? phase_in : pend;
            end
        end
    end

endmodule

// File: tb/tb_sine_addr_gen.sv
// Directed self-checking bench for sine_addr_gen.
// Drives inputs 1ns after the rising edge, checks 1ns later.
module tb_sine_addr_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        en;
    logic [15:0] incr;
    logic [15:0] burst_len;
    logic [7:0]  phase_in;
    logic        phase_load;
    logic [7:0]  addr;
    logic [7:0]  phase;
    logic        addr_valid;
    logic        wrap;
    logic        rom_valid;
    logic        busy;
    logic        done;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    sine_addr_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .en         (en),
        .incr       (incr),
        .burst_len  (burst_len),
        .phase_in   (phase_in),
        .phase_load (phase_load),
        .addr       (addr),
        .phase      (phase),
        .addr_valid (addr_valid),
        .wrap       (wrap),
        .rom_valid  (rom_valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 0; stop = 0; en = 0;
        incr = '0; burst_len = '0; phase_in = '0; phase_load = 0;
        #3;
        chk("rst_addr", addr, 0);
        chk("rst_phase", phase, 0);
        chk("rst_av", addr_valid, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_rv", rom_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // burst of 4, incr 0x0100
        start = 1; incr = 16'h0100; burst_len = 16'd4; en = 1;
        cyc();
        start = 0;
        #1;
        chk("a_busy0", busy, 1);
        chk("a_addr0", addr, 0);
        chk("a_av0", addr_valid, 1);
        chk("a_rv0", rom_valid, 0);
        chk("a_done0", done, 0);
        for (int i = 1; i < 4; i++) begin
            cyc();
            chk("a_addr", addr, i);
            chk("a_rv", rom_valid, 1);
            chk("a_busy", busy, 1);
            chk("a_done", done, 0);
        end
        cyc();
        chk("a_busy_end", busy, 0);
        chk("a_done_end", done, 1);
        chk("a_rv_end", rom_valid, 1);
        chk("a_av_end", addr_valid, 0);
        cyc();
        chk("a_done_clr", done, 0);
        chk("a_rv_clr", rom_valid, 0);

        // continuous, incr 0x8000, then stop
        start = 1; incr = 16'h8000; burst_len = 16'd0;
        cyc();
        start = 0;
        #1;
        chk("b_addr0", addr, 0);
        chk("b_wrap0", wrap, 0);
        cyc();
        chk("b_addr1", addr, 128);
        chk("b_wrap1", wrap, 1);
        cyc();
        chk("b_addr2", addr, 0);
        chk("b_wrap2", wrap, 0);
        cyc();
        chk("b_addr3", addr, 128);
        chk("b_wrap3", wrap, 1);
        stop = 1;
        cyc();
        stop = 0;
        #1;
        chk("b_busy_stop", busy, 0);
        chk("b_addr_hold", addr, 128);

        // stop+start in IDLE enters RUN; start during RUN is ignored
        stop = 1; start = 1; incr = 16'h0100;
        cyc();
        stop = 0; start = 0;
        #1;
        chk("e_busy", busy, 1);
        chk("e_addr0", addr, 0);
        cyc();
        chk("e_addr1", addr, 1);
        cyc();
        start = 1; incr = 16'h4000;
        #1;
        chk("e_addr2", addr, 2);
        cyc();
        start = 0;
        #1;
        chk("e_addr3", addr, 3);
        chk("e_busy3", busy, 1);
        stop = 1;
        cyc();
        stop = 0;
        #1;
        chk("e_busy_end", busy, 0);

        // phase load mid-run applies at first wrap
        start = 1; incr = 16'h1000;
        cyc();
        start = 0;
        for (int j = 0; j < 16; j++) begin
            if (j > 0) cyc();
            phase_load = (j == 2);
            phase_in = 8'h20;
            #1;
            chk("c_addr", addr, (j * 16) & 32'hFF);
            chk("c_phase_hold", phase, 0);
            if (j == 15) chk("c_wrap", wrap, 1);
        end
        cyc();
        #1;
        chk("c_phase_new", phase, 8'h20);
        chk("c_addr_wrap", addr, 0);
        stop = 1;
        cyc();
        stop = 0;
        phase_in = 8'h40; phase_load = 1;
        #1;
        chk("c_idle_pre", phase, 8'h20);
        cyc();
        phase_load = 0;
        #1;
        chk("c_idle_load", phase, 8'h40);

        // burst 3 with a 2-cycle stall after the first issue
        start = 1; incr = 16'h0100; burst_len = 16'd3; en = 1;
        cyc();
        start = 0;
        #1;
        chk("d_addr0", addr, 0);
        chk("d_av0", addr_valid, 1);
        cyc();
        en = 0;
        #1;
        chk("d_addr1", addr, 1);
        chk("d_av1", addr_valid, 0);
        chk("d_rv1", rom_valid, 1);
        cyc();
        chk("d_addr2", addr, 1);
        chk("d_av2", addr_valid, 0);
        chk("d_rv2", rom_valid, 0);
        cyc();
        en = 1;
        #1;
        chk("d_addr3", addr, 1);
        chk("d_av3", addr_valid, 1);
        cyc();
        chk("d_addr4", addr, 2);
        chk("d_busy4", busy, 1);
        chk("d_done4", done, 0);
        cyc();
        chk("d_busy5", busy, 0);
        chk("d_done5", done, 1);
        chk("d_addr5", addr, 3);

        // asynchronous reset mid-burst
        start = 1; incr = 16'h0100; burst_len = 16'd8;
        cyc();
        start = 0;
        cyc();
        cyc();
        chk("f_addr_pre", addr, 2);
        chk("f_busy_pre", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("f_addr", addr, 0);
        chk("f_phase", phase, 0);
        chk("f_busy", busy, 0);
        chk("f_av", addr_valid, 0);
        chk("f_rv", rom_valid, 0);
        chk("f_wrap", wrap, 0);
        chk("f_done", done, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("f_done_post", done, 0);
        start = 1;
        cyc();
        start = 0;
        #1;
        chk("f_re_addr0", addr, 0);
        chk("f_re_busy", busy, 1);
        cyc();
        chk("f_re_addr1", addr, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
